// File: rtl/uiarp_pkg.sv
// Shared ARP constants, FSM state encoding and the ARP body byte selector
// used by the ARP transmit message queue.
package uiarp_pkg;

  localparam logic [15:0] ARP_HTYPE    = 16'h0001;
  localparam logic [15:0] ARP_PTYPE    = 16'h0800;
  localparam logic [7:0]  ARP_HLEN     = 8'h06;
  localparam logic [7:0]  ARP_PLEN     = 8'h04;
  localparam logic [15:0] OPER_REQUEST = 16'h0001;
  localparam logic [15:0] OPER_REPLY   = 16'h0002;
  localparam logic [47:0] BCAST_MAC    = 48'hFFFF_FFFF_FFFF;
  localparam int          ARP_BODY_LEN = 28;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_GRANT,
    ST_SEND,
    ST_PAD
  } arp_state_t;

  typedef struct packed {
    logic [47:0] mac;
    logic [31:0] ip;
  } rpl_entry_t;

  // Byte idx of the 28-byte ARP body, MSB first; indices past the body read as zero pad.
  function automatic logic [7:0] arp_body_byte(
    input logic [5:0]  idx,
    input logic [15:0] oper,
    input logic [47:0] sha,
    input logic [31:0] spa,
    input logic [47:0] tha,
    input logic [31:0] tpa
  );
    logic [223:0] body;
    body = {ARP_HTYPE, ARP_PTYPE, ARP_HLEN, ARP_PLEN, oper, sha, spa, tha, tpa};
    body = body << {idx, 3'b000};
    return (idx < 6'(ARP_BODY_LEN)) ? body[223:216] : 8'h00;
  endfunction

endpackage

// File: rtl/uiarp_tx_mq_if.sv
// Push strobes, local addressing and the byte-stream side of the ARP tx queue.
interface uiarp_tx_mq_if;
  logic [47:0] I_mac_local_addr;
  logic [31:0] I_ip_local_addr;
  logic        I_arp_treq_en;
  logic [31:0] I_arp_tip_addr;
  logic        I_arp_rreply_en;
  logic [31:0] I_arp_rreply_ip_addr;
  logic [47:0] I_arp_rreply_mac_addr;
  logic        I_garp_en;
  logic        I_arp_tbusy;
  logic        O_arp_treq;
  logic        O_arp_tvalid;
  logic [7:0]  O_arp_tdata;
  logic        O_arp_ttype;
  logic [47:0] O_arp_tdest_mac_addr;
  logic        O_req_full;
  logic        O_rpl_full;
  logic [15:0] O_drop_cnt;

  modport slave (
    input  I_mac_local_addr, I_ip_local_addr, I_arp_treq_en, I_arp_tip_addr,
           I_arp_rreply_en, I_arp_rreply_ip_addr, I_arp_rreply_mac_addr,
           I_garp_en, I_arp_tbusy,
    output O_arp_treq, O_arp_tvalid, O_arp_tdata, O_arp_ttype,
           O_arp_tdest_mac_addr, O_req_full, O_rpl_full, O_drop_cnt
  );

  modport master (
    output I_mac_local_addr, I_ip_local_addr, I_arp_treq_en, I_arp_tip_addr,
           I_arp_rreply_en, I_arp_rreply_ip_addr, I_arp_rreply_mac_addr,
           I_garp_en, I_arp_tbusy,
    input  O_arp_treq, O_arp_tvalid, O_arp_tdata, O_arp_ttype,
           O_arp_tdest_mac_addr, O_req_full, O_rpl_full, O_drop_cnt
  );
endinterface

// File: rtl/uiarp_tx_fifo.sv
// Show-ahead FIFO for the ARP request/reply queues; pushes while full and
// pops while empty are ignored, simultaneous push and pop both take effect.
module uiarp_tx_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             I_arp_clk,
  input  logic             I_arp_reset,
  input  logic             I_push,
  input  logic             I_pop,
  input  logic [WIDTH-1:0] I_wdata,
  output logic [WIDTH-1:0] O_rdata,
  output logic             O_full,
  output logic             O_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign O_full  = (count_q == (AW+1)'(DEPTH));
  assign O_empty = (count_q == '0);
  assign O_rdata = mem_q[rd_ptr_q];
  assign do_push = I_push & ~O_full;
  assign do_pop  = I_pop & ~O_empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  always_ff @(posedge I_arp_clk or posedge I_arp_reset) begin
    if (I_arp_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset: occupancy alone decides what is valid.
  always_ff @(posedge I_arp_clk) begin
    if (do_push) mem_q[wr_ptr_q] <= I_wdata;
  end

endmodule

// File: rtl/uiarp_tx_mq.sv
// ARP transmit message queue: buffers request/reply/GARP triggers and serialises
// one padded ARP body at a time onto the tx mux byte stream.
module uiarp_tx_mq
  import uiarp_pkg::*;
#(
  parameter int REQ_DEPTH  = 4,
  parameter int RPL_DEPTH  = 4,
  parameter int PAD_LEN    = 18,
  parameter int PRIO_REPLY = 1,
  parameter int DEDUP_EN   = 1
) (
  input logic          I_arp_clk,
  input logic          I_arp_reset,
  uiarp_tx_mq_if.slave arp
);

  localparam logic [5:0] FRAME_LEN = 6'(ARP_BODY_LEN + PAD_LEN);
  localparam logic [5:0] BODY_LEN  = 6'(ARP_BODY_LEN);

  arp_state_t  state_q, state_d;
  logic [15:0] oper_q, oper_d;
  logic [31:0] tpa_q, tpa_d;
  logic [47:0] tha_q, tha_d;
  logic [5:0]  idx_q, idx_d;
  logic        treq_q, treq_d;
  logic        tvalid_q, tvalid_d;
  logic [7:0]  tdata_q, tdata_d;
  logic        ttype_q, ttype_d;
  logic [47:0] tdest_q, tdest_d;
  logic        garp_q, garp_d;
  logic [31:0] req_last_q, req_last_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;

  logic        req_push, req_pop, req_full, req_empty, req_dup, req_drop;
  logic        rpl_pop, rpl_full, rpl_empty, rpl_drop;
  logic [31:0] req_head;
  rpl_entry_t  rpl_wdata, rpl_head;
  logic        take_rpl, take_req, take_garp, is_req;
  logic [16:0] drop_sum;

  assign rpl_wdata = '{mac: arp.I_arp_rreply_mac_addr, ip: arp.I_arp_rreply_ip_addr};

  // The newest stored request IP is the last one accepted while the queue stays non-empty.
  assign req_dup  = (DEDUP_EN != 0) && !req_empty && (req_last_q == arp.I_arp_tip_addr);
  assign req_push = arp.I_arp_treq_en & ~req_dup;
  assign req_drop = req_push & req_full;
  assign rpl_drop = arp.I_arp_rreply_en & rpl_full;

  uiarp_tx_fifo #(.WIDTH(32), .DEPTH(REQ_DEPTH)) u_req_fifo (
    .I_arp_clk   (I_arp_clk),
    .I_arp_reset (I_arp_reset),
    .I_push      (req_push),
    .I_pop       (req_pop),
    .I_wdata     (arp.I_arp_tip_addr),
    .O_rdata     (req_head),
    .O_full      (req_full),
    .O_empty     (req_empty)
  );

  uiarp_tx_fifo #(.WIDTH(80), .DEPTH(RPL_DEPTH)) u_rpl_fifo (
    .I_arp_clk   (I_arp_clk),
    .I_arp_reset (I_arp_reset),
    .I_push      (arp.I_arp_rreply_en),
    .I_pop       (rpl_pop),
    .I_wdata     (rpl_wdata),
    .O_rdata     (rpl_head),
    .O_full      (rpl_full),
    .O_empty     (rpl_empty)
  );

  assign take_rpl  = !rpl_empty && ((PRIO_REPLY != 0) || req_empty);
  assign take_req  = !req_empty && !take_rpl;
  assign take_garp = garp_q && req_empty && rpl_empty;
  assign is_req    = (oper_q == OPER_REQUEST);
  assign drop_sum  = 17'(drop_cnt_q) + 17'(req_drop) + 17'(rpl_drop);

  always_comb begin
    state_d    = state_q;
    oper_d     = oper_q;
    tpa_d      = tpa_q;
    tha_d      = tha_q;
    idx_d      = idx_q;
    treq_d     = treq_q;
    tvalid_d   = tvalid_q;
    tdata_d    = tdata_q;
    ttype_d    = ttype_q;
    tdest_d    = tdest_q;
    req_pop    = 1'b0;
    rpl_pop    = 1'b0;
    req_last_d = (req_push && !req_full) ? arp.I_arp_tip_addr : req_last_q;
    drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    garp_d     = garp_q ? 1'b1 : arp.I_garp_en;

    unique case (state_q)
      ST_IDLE: begin
        if (take_rpl) begin
          rpl_pop = 1'b1;
          oper_d  = OPER_REPLY;
          tpa_d   = rpl_head.ip;
          tha_d   = rpl_head.mac;
        end else if (take_req) begin
          req_pop = 1'b1;
          oper_d  = OPER_REQUEST;
          tpa_d   = req_head;
          tha_d   = '0;
        end else if (take_garp) begin
          garp_d  = 1'b0;
          oper_d  = OPER_REQUEST;
          tpa_d   = arp.I_ip_local_addr;
          tha_d   = '0;
        end
        if (take_rpl || take_req || take_garp) begin
          treq_d  = 1'b1;
          state_d = ST_WAIT_GRANT;
        end
      end

      ST_WAIT_GRANT: begin
        if (treq_q && arp.I_arp_tbusy) begin
          treq_d   = 1'b0;
          tvalid_d = 1'b1;
          tdata_d  = arp_body_byte(6'd0, oper_q, arp.I_mac_local_addr,
                                   arp.I_ip_local_addr, tha_q, tpa_q);
          ttype_d  = is_req;
          tdest_d  = is_req ? BCAST_MAC : tha_q;
          idx_d    = 6'd1;
          state_d  = ST_SEND;
        end
      end

      // idx_q counts bytes already on the wire; pad bytes come out of the same selector as zeros.
      ST_SEND, ST_PAD: begin
        if (idx_q < FRAME_LEN) begin
          tdata_d = arp_body_byte(idx_q, oper_q, arp.I_mac_local_addr,
                                  arp.I_ip_local_addr, tha_q, tpa_q);
          idx_d   = idx_q + 6'd1;
          state_d = (idx_q >= BODY_LEN) ? ST_PAD : ST_SEND;
        end else begin
          tvalid_d = 1'b0;
          tdata_d  = '0;
          ttype_d  = 1'b0;
          tdest_d  = '0;
          idx_d    = '0;
          state_d  = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge I_arp_clk or posedge I_arp_reset) begin
    if (I_arp_reset) begin
      state_q    <= ST_IDLE;
      oper_q     <= '0;
      tpa_q      <= '0;
      tha_q      <= '0;
      idx_q      <= '0;
      treq_q     <= 1'b0;
      tvalid_q   <= 1'b0;
      tdata_q    <= '0;
      ttype_q    <= 1'b0;
      tdest_q    <= '0;
      garp_q     <= 1'b0;
      req_last_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      oper_q     <= oper_d;
      tpa_q      <= tpa_d;
      tha_q      <= tha_d;
      idx_q      <= idx_d;
      treq_q     <= treq_d;
      tvalid_q   <= tvalid_d;
      tdata_q    <= tdata_d;
      ttype_q    <= ttype_d;
      tdest_q    <= tdest_d;
      garp_q     <= garp_d;
      req_last_q <= req_last_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign arp.O_arp_treq           = treq_q;
  assign arp.O_arp_tvalid         = tvalid_q;
  assign arp.O_arp_tdata          = tdata_q;
  assign arp.O_arp_ttype          = ttype_q;
  assign arp.O_arp_tdest_mac_addr = tdest_q;
  assign arp.O_req_full           = req_full;
  assign arp.O_rpl_full           = rpl_full;
  assign arp.O_drop_cnt           = drop_cnt_q;

endmodule
